// File: rtl/p2s_lane.sv
`default_nettype none
// ============================================================================
// Module   : p2s_lane
// Purpose  : Parameterised parallel-to-serial converter. Takes an N-bit word
//            on a valid/ready parallel port and emits it as N/W beats of W
//            bits on a valid/ready serial port. The lane order is selectable,
//            the final beat of each word is flagged, and back-to-back words
//            run without a bubble: the next word loads on the same edge that
//            the last beat of the current word is consumed.
// Ports    : clk_i      - clock, rising edge
//            rstn_i     - asynchronous active-low reset
//            p_valid_i  - parallel word valid
//            p_data_i   - parallel word [N-1:0]
//            p_ready_o  - word can be accepted this cycle (depends on s_ready_i)
//            s_valid_o  - serial beat valid
//            s_data_o   - serial beat data [W-1:0]
//            s_last_o   - current beat is the last beat of the word
//            s_ready_i  - downstream accepts the beat this cycle
// Revision : 1.0 - initial release
// ============================================================================
module p2s_lane #(
  parameter int N         = 8,
  parameter int W         = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         p_valid_i,
  input  logic [N-1:0] p_data_i,
  output logic         p_ready_o,
  output logic         s_valid_o,
  output logic [W-1:0] s_data_o,
  output logic         s_last_o,
  input  logic         s_ready_i
);

  localparam int            BEATS = N / W;
  localparam int            CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST  = CW'(BEATS - 1);

  // A word that does not split into whole lanes has no sensible meaning.
  generate
    if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_params
      $error("p2s_lane: N must be a non-zero multiple of W (N=%0d W=%0d)", N, W);
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [N-1:0]  shift_q;
  logic          s_valid_q;
  logic          s_last_q;

  logic [N-1:0]  shift_d;   // register advanced by one lane
  logic [CW-1:0] count_d;   // beat index advanced by one

  assign count_d = count_q + CW'(1);

  // Lane selection and shift direction. With a single beat per word there is
  // nothing left after the beat, so the advanced value is simply empty.
  generate
    if (BEATS == 1) begin : g_single
      assign shift_d  = '0;
      assign s_data_o = shift_q;
    end else if (MSB_FIRST) begin : g_msb_first
      assign shift_d  = {shift_q[N-W-1:0], {W{1'b0}}};
      assign s_data_o = shift_q[N-1 -: W];
    end else begin : g_lsb_first
      assign shift_d  = {{W{1'b0}}, shift_q[N-1:W]};
      assign s_data_o = shift_q[W-1:0];
    end
  endgenerate

  // Ready while idle, or when the last beat is being taken this very cycle;
  // the latter is what allows the zero-bubble reload.
  assign p_ready_o = (state_q == IDLE) || (s_ready_i && (count_q == LAST));

  assign s_valid_o = s_valid_q;
  assign s_last_o  = s_last_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      shift_q   <= '0;
      s_valid_q <= 1'b0;
      s_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (p_valid_i) begin
            shift_q   <= p_data_i;
            count_q   <= '0;
            state_q   <= SEND;
            s_valid_q <= 1'b1;
            s_last_q  <= (BEATS == 1);
          end
        end

        SEND: begin
          // Without s_ready_i everything holds, keeping the beat stable.
          if (s_ready_i) begin
            if (count_q == LAST) begin
              count_q <= '0;
              if (p_valid_i) begin
                shift_q  <= p_data_i;
                s_last_q <= (BEATS == 1);
              end else begin
                // Advancing once more flushes the register to zero.
                shift_q   <= shift_d;
                state_q   <= IDLE;
                s_valid_q <= 1'b0;
                s_last_q  <= 1'b0;
              end
            end else begin
              shift_q  <= shift_d;
              count_q  <= count_d;
              s_last_q <= (count_d == LAST);
            end
          end
        end

        default: begin
          state_q   <= IDLE;
          count_q   <= '0;
          shift_q   <= '0;
          s_valid_q <= 1'b0;
          s_last_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
